sipo_deser: RTL and testbench

- Serial-in/parallel-out deserializer: collects single bits from a serial source and assembles them into WIDTH-bit words.
- Sits directly upstream of the catalog D flip-flop/register stage and produces the 4-bit words that stage captures.
- Valid/ready handshake on both the serial input and the parallel output.
- One output holding register plus the shift register gives one word of buffering under backpressure.

---
 rtl/sipo_deser.sv | 146 ++++++++++++++
 tb/tb_sipo_deser.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer with valid/ready on both sides.
// Optional even-parity trailer bit per word enabled by SIPO_DESER_PARITY_EN.
module sipo_deser #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             SIN,
    input  logic             SIN_VALID,
    output logic             SIN_READY,
    output logic [WIDTH-1:0] Q,
    output logic             Q_VALID,
    input  logic             Q_READY,
    output logic             PAR_ERR
);

`ifdef SIPO_DESER_PARITY_EN
    localparam int unsigned N = WIDTH + 1;
`else
    localparam int unsigned N = WIDTH;
`endif
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             q_valid_q, q_valid_d;
    logic             sin_ready_q, sin_ready_d;
`ifdef SIPO_DESER_PARITY_EN
    logic             par_acc_q, par_acc_d;
    logic             par_err_q, par_err_d;
`endif

    logic             out_free_c;
    logic [WIDTH-1:0] shift_in_c;

    // Next-state, datapath and handshake decode
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        q_d         = q_q;
        q_valid_d   = q_valid_q & ~Q_READY;
`ifdef SIPO_DESER_PARITY_EN
        par_acc_d   = par_acc_q;
        par_err_d   = par_err_q;
`endif
        out_free_c  = ~q_valid_q | Q_READY;
        shift_in_c  = MSB_FIRST ? {shift_q[WIDTH-2:0], SIN}
                                : {SIN, shift_q[WIDTH-1:1]};

        case (state_q)
            FILL: begin
                if (SIN_VALID) begin
`ifdef SIPO_DESER_PARITY_EN
                    // Trailing parity bit only feeds the accumulator, never the word
                    if (cnt_q < CW'(WIDTH)) begin
                        shift_d = shift_in_c;
                    end
                    par_acc_d = par_acc_q ^ SIN;
`else
                    shift_d = shift_in_c;
`endif
                    if (cnt_q == CW'(N - 1)) begin
                        if (out_free_c) begin
                            q_d       = shift_d;
                            q_valid_d = 1'b1;
                            cnt_d     = '0;
`ifdef SIPO_DESER_PARITY_EN
                            par_err_d = par_acc_d;
                            par_acc_d = 1'b0;
`endif
                        end else begin
                            state_d = FULL;
                            cnt_d   = cnt_q + CW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            FULL: begin
                if (out_free_c) begin
                    q_d       = shift_q;
                    q_valid_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = FILL;
`ifdef SIPO_DESER_PARITY_EN
                    par_err_d = par_acc_q;
                    par_acc_d = 1'b0;
`endif
                end
            end
            default: begin
                state_d = FILL;
                cnt_d   = '0;
            end
        endcase

        sin_ready_d = (state_d == FILL);
    end

    // State and output registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            shift_q     <= '0;
            q_q         <= '0;
            q_valid_q   <= 1'b0;
            sin_ready_q <= 1'b1;
`ifdef SIPO_DESER_PARITY_EN
            par_acc_q   <= 1'b0;
            par_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            q_q         <= q_d;
            q_valid_q   <= q_valid_d;
            sin_ready_q <= sin_ready_d;
`ifdef SIPO_DESER_PARITY_EN
            par_acc_q   <= par_acc_d;
            par_err_q   <= par_err_d;
`endif
        end
    end

    assign SIN_READY = sin_ready_q;
    assign Q         = q_q;
    assign Q_VALID   = q_valid_q;
`ifdef SIPO_DESER_PARITY_EN
    assign PAR_ERR   = par_err_q;
`else
    assign PAR_ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser: MSB-first and LSB-first instances, backpressure,
// consume-and-load streaming, mid-word reset, and parity when SIPO_DESER_PARITY_EN is set.
module tb_sipo_deser;

`ifdef SIPO_DESER_PARITY_EN
    localparam int unsigned N = 5;
`else
    localparam int unsigned N = 4;
`endif

    logic       clk;
    logic       rst_n;
    logic       sin_a, sin_valid_a, sin_ready_a, q_valid_a, q_ready_a, par_err_a;
    logic [3:0] q_a;
    logic       sin_b, sin_valid_b, sin_ready_b, q_valid_b, q_ready_b, par_err_b;
    logic [3:0] q_b;

    int n_checks = 0;
    int n_errors = 0;
    int stalls   = 0;

    sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
        .CLK(clk), .RST_N(rst_n), .SIN(sin_a), .SIN_VALID(sin_valid_a),
        .SIN_READY(sin_ready_a), .Q(q_a), .Q_VALID(q_valid_a),
        .Q_READY(q_ready_a), .PAR_ERR(par_err_a)
    );

    sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .CLK(clk), .RST_N(rst_n), .SIN(sin_b), .SIN_VALID(sin_valid_b),
        .SIN_READY(sin_ready_b), .Q(q_b), .Q_VALID(q_valid_b),
        .Q_READY(q_ready_b), .PAR_ERR(par_err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the bit transferred
    task automatic push_a(input logic b);
        int n;
        n = 0;
        sin_a       = b;
        sin_valid_a = 1'b1;
        while (!sin_ready_a && n < 50) begin
            @(negedge clk);
            n++;
            stalls++;
        end
        if (n >= 50) check("ready_timeout_a", 32'd1, 32'd0);
        @(negedge clk);
        sin_valid_a = 1'b0;
    endtask

    task automatic push_b(input logic b);
        int n;
        n = 0;
        sin_b       = b;
        sin_valid_b = 1'b1;
        while (!sin_ready_b && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout_b", 32'd1, 32'd0);
        @(negedge clk);
        sin_valid_b = 1'b0;
    endtask

    // MSB-first data bits, then even parity bit when enabled
    task automatic push_word_a(input logic [3:0] d);
        for (int i = 3; i >= 0; i--) push_a(d[i]);
`ifdef SIPO_DESER_PARITY_EN
        push_a(^d);
`endif
    endtask

    initial begin
        logic [3:0] words [3];
        logic [3:0] w;
        logic       b;
        words[0] = 4'hA;
        words[1] = 4'h5;
        words[2] = 4'hF;

        rst_n       = 1'b0;
        sin_a       = 1'b0;
        sin_valid_a = 1'b0;
        q_ready_a   = 1'b1;
        sin_b       = 1'b0;
        sin_valid_b = 1'b0;
        q_ready_b   = 1'b1;

        #12;
        check("rst_q", 32'(q_a), 32'h0);
        check("rst_q_valid", 32'(q_valid_a), 32'h0);
        check("rst_par_err", 32'(par_err_a), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_sin_ready", 32'(sin_ready_a), 32'h1);
        @(negedge clk);

        // Basic word, MSB first
        push_word_a(4'b1011);
        check("basic_q", 32'(q_a), 32'hB);
        check("basic_q_valid", 32'(q_valid_a), 32'h1);
        check("basic_par_err", 32'(par_err_a), 32'h0);
        @(negedge clk);
        check("basic_consumed", 32'(q_valid_a), 32'h0);
        check("basic_q_hold", 32'(q_a), 32'hB);

        // LSB first with a 3-cycle gap mid-word
        push_b(1'b1);
        push_b(1'b0);
        repeat (3) @(negedge clk);
        push_b(1'b0);
        push_b(1'b0);
`ifdef SIPO_DESER_PARITY_EN
        push_b(1'b1);
`endif
        check("lsb_q", 32'(q_b), 32'h1);
        check("lsb_q_valid", 32'(q_valid_b), 32'h1);

        // Backpressure: second word parks in the shift register
        q_ready_a = 1'b0;
        push_word_a(4'b1100);
        check("bp_q1", 32'(q_a), 32'hC);
        check("bp_q1_valid", 32'(q_valid_a), 32'h1);
        push_word_a(4'b0011);
        check("bp_full_ready", 32'(sin_ready_a), 32'h0);
        check("bp_q_hold", 32'(q_a), 32'hC);
        repeat (2) @(negedge clk);
        check("bp_q_hold2", 32'(q_a), 32'hC);
        check("bp_valid_hold", 32'(q_valid_a), 32'h1);
        check("bp_ready_low", 32'(sin_ready_a), 32'h0);
        q_ready_a = 1'b1;
        @(negedge clk);
        q_ready_a = 1'b0;
        check("bp_q2", 32'(q_a), 32'h3);
        check("bp_q2_valid", 32'(q_valid_a), 32'h1);
        check("bp_ready_back", 32'(sin_ready_a), 32'h1);

        // Continuous stream; consume coincides with each new load
        stalls = 0;
        for (int k = 0; k < 3; k++) begin
            w = words[k];
            for (int i = 0; i < int'(N); i++) begin
                b = (i < 4) ? w[3 - (i % 4)] : ^w;
                check("stream_valid", 32'(q_valid_a), 32'h1);
                if (i == int'(N) - 1) q_ready_a = 1'b1;
                push_a(b);
                q_ready_a = 1'b0;
            end
            check("stream_q", 32'(q_a), 32'(w));
            check("stream_q_valid", 32'(q_valid_a), 32'h1);
        end
        check("stream_stalls", 32'(stalls), 32'h0);

        // Reset after 2 bits discards the partial word
        q_ready_a = 1'b1;
        push_a(1'b1);
        push_a(1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_q", 32'(q_a), 32'h0);
        check("mid_rst_q_valid", 32'(q_valid_a), 32'h0);
        check("mid_rst_par_err", 32'(par_err_a), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rel_ready", 32'(sin_ready_a), 32'h1);
        @(negedge clk);
        push_word_a(4'b0110);
        check("post_rst_q", 32'(q_a), 32'h6);
        check("post_rst_q_valid", 32'(q_valid_a), 32'h1);

`ifdef SIPO_DESER_PARITY_EN
        push_a(1'b1); push_a(1'b0); push_a(1'b1); push_a(1'b1); push_a(1'b1);
        check("par_ok_q", 32'(q_a), 32'hB);
        check("par_ok_err", 32'(par_err_a), 32'h0);
        push_a(1'b1); push_a(1'b0); push_a(1'b1); push_a(1'b1); push_a(1'b0);
        check("par_bad_q", 32'(q_a), 32'hB);
        check("par_bad_err", 32'(par_err_a), 32'h1);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
